// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
// Arbitration helpers work on a fixed 4-bit request space; unused upper bits are zero.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam int MAX_MASTERS   = 4;
    localparam int DAT_W_DEFAULT = 32;
    localparam int SEL_W         = DAT_W_DEFAULT / 8;

    // First requester found searching upward from last+1, wrapping at n.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [1:0]             last,
        input int                     n
    );
        logic [MAX_MASTERS-1:0] pick;
        int                     idx;
        pick = '0;
        for (int k = 1; k <= MAX_MASTERS; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && pick == '0 && req[idx[1:0]]) begin
                pick[idx[1:0]] = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [1:0] oh_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_MASTERS; k++) begin
            if (oh[k]) begin
                idx = 2'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_watchdog.sv
// Stall watchdog: counts strobed-but-unacked cycles of the granted master and
// flags the cycle that would be the TIMEOUT-th stall. TIMEOUT of 0 disables it.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic busy,
    input  logic stb,
    input  logic ack,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (!busy || !stb || ack) begin
            count_d = '0;
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    // An ack in the terminal cycle wins, so tc requires !ack.
    assign tc = (TIMEOUT != 0) && busy && stb && !ack && (count_q == CNT_LAST);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: registered grant, combinational data path
// between the granted master and the shared slave, watchdog-driven abort.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADR_W       = 32,
    parameter int DAT_W       = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_MASTERS-1:0]             m_cyc,
    input  logic [NUM_MASTERS-1:0]             m_stb,
    input  logic [NUM_MASTERS-1:0]             m_we,
    input  logic [NUM_MASTERS*(DAT_W/8)-1:0]   m_sel,
    input  logic [NUM_MASTERS*ADR_W-1:0]       m_adr,
    input  logic [NUM_MASTERS*DAT_W-1:0]       m_dat_w,
    output logic [DAT_W-1:0]                   m_dat_r,
    output logic [NUM_MASTERS-1:0]             m_ack,
    output logic [NUM_MASTERS-1:0]             m_err,
    output logic                               s_cyc,
    output logic                               s_stb,
    output logic                               s_we,
    output logic [DAT_W/8-1:0]                 s_sel,
    output logic [ADR_W-1:0]                   s_adr,
    output logic [DAT_W-1:0]                   s_dat_w,
    input  logic [DAT_W-1:0]                   s_dat_r,
    input  logic                               s_ack,
    output logic [NUM_MASTERS-1:0]             grant
);

    localparam int SW = DAT_W / 8;

    arb_state_e               state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [1:0]               last_q, last_d;
    logic [MAX_MASTERS-1:0]   req_pad;
    logic [MAX_MASTERS-1:0]   pick;
    logic                     busy;
    logic                     wd_tc;

    logic                     sel_cyc;
    logic                     sel_stb;
    logic                     sel_we;
    logic [SW-1:0]            sel_sel;
    logic [ADR_W-1:0]         sel_adr;
    logic [DAT_W-1:0]         sel_dat;

    assign busy    = (state_q == BUSY);
    assign grant   = grant_q;
    assign m_dat_r = s_dat_r;

    always_comb begin
        req_pad                  = '0;
        req_pad[NUM_MASTERS-1:0] = m_cyc;
    end

    assign pick = rr_pick(req_pad, last_q, NUM_MASTERS);

    // Master-side signals of the current owner; all zero when nobody is granted.
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_sel = '0;
        sel_adr = '0;
        sel_dat = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                sel_cyc = m_cyc[i];
                sel_stb = m_stb[i];
                sel_we  = m_we[i];
                sel_sel = m_sel[i*SW +: SW];
                sel_adr = m_adr[i*ADR_W +: ADR_W];
                sel_dat = m_dat_w[i*DAT_W +: DAT_W];
            end
        end
    end

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .busy    (busy),
        .stb     (sel_stb),
        .ack     (s_ack),
        .tc      (wd_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 2'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (|m_cyc) begin
                    grant_d = pick[NUM_MASTERS-1:0];
                    last_d  = oh_to_idx(pick);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (wd_tc) begin
                    grant_d = '0;
                    state_d = ABORT;
                end else if (!sel_cyc) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            ABORT: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // The abort cycle hides the strobe from the slave while err goes back to the master.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_w = '0;
        m_ack   = '0;
        m_err   = '0;
        if (busy) begin
            s_cyc   = sel_cyc & ~wd_tc;
            s_stb   = sel_stb & ~wd_tc;
            s_we    = sel_we;
            s_sel   = sel_sel;
            s_adr   = sel_adr;
            s_dat_w = sel_dat;
            m_ack   = grant_q & {NUM_MASTERS{s_ack & sel_stb}};
            m_err   = grant_q & {NUM_MASTERS{wd_tc}};
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed, table-driven bench for wb_rr_arbiter with two masters and a
// short watchdog so abort and ack-at-terminal-count are reachable quickly.
module tb_wb_rr_arbiter;

    localparam int NM  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic              clk;
    logic              reset_n;
    logic [NM-1:0]     m_cyc;
    logic [NM-1:0]     m_stb;
    logic [NM-1:0]     m_we;
    logic [NM*4-1:0]   m_sel;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat_w;
    logic [DW-1:0]     m_dat_r;
    logic [NM-1:0]     m_ack;
    logic [NM-1:0]     m_err;
    logic              s_cyc;
    logic              s_stb;
    logic              s_we;
    logic [3:0]        s_sel;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_w;
    logic [DW-1:0]     s_dat_r;
    logic              s_ack;
    logic [NM-1:0]     grant;

    wb_rr_arbiter #(
        .NUM_MASTERS (NM),
        .ADR_W       (AW),
        .DAT_W       (DW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_sel   (m_sel),
        .m_adr   (m_adr),
        .m_dat_w (m_dat_w),
        .m_dat_r (m_dat_r),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_sel   (s_sel),
        .s_adr   (s_adr),
        .s_dat_w (s_dat_w),
        .s_dat_r (s_dat_r),
        .s_ack   (s_ack),
        .grant   (grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic [1:0] cyc;
        logic [1:0] stb;
        logic       ack;
        logic [1:0] e_grant;
        logic       e_scyc;
        logic       e_sstb;
        logic [1:0] e_mack;
        logic [1:0] e_merr;
    } vec_t;

    vec_t        vecs [64];
    int          nv;
    int          vectors;
    int          miscompares;
    logic [31:0] exp_dat_r;

    function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [1:0] s,
                                input logic a, input logic [1:0] g, input logic sc,
                                input logic ss, input logic [1:0] ma, input logic [1:0] me);
        vec_t v;
        v.rst_n   = r;
        v.cyc     = c;
        v.stb     = s;
        v.ack     = a;
        v.e_grant = g;
        v.e_scyc  = sc;
        v.e_sstb  = ss;
        v.e_mack  = ma;
        v.e_merr  = me;
        return v;
    endfunction

    task automatic addVec(input vec_t v);
        vecs[nv] = v;
        nv++;
    endtask

    task automatic checkField(input string tag, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s %s: got %h expected %h", tag, field, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset_n   = v.rst_n;
        m_cyc     = v.cyc;
        m_stb     = v.stb;
        s_ack     = v.ack;
        exp_dat_r = 32'hCAFE0000 | 32'(vectors);
        s_dat_r   = exp_dat_r;
        vectors++;
    endtask

    // Mux-side expectations follow from which master the vector says is granted.
    task automatic checkOutput(input vec_t v, input string tag);
        logic [31:0] e_adr;
        logic [31:0] e_dat;
        logic        e_we;
        logic [3:0]  e_sel;
        e_adr = 32'h0;
        e_dat = 32'h0;
        e_we  = 1'b0;
        e_sel = 4'h0;
        if (v.e_grant == 2'b01) begin
            e_adr = 32'h0000_0010;
            e_dat = 32'hDEAD_BEEF;
            e_we  = 1'b1;
            e_sel = 4'hF;
        end else if (v.e_grant == 2'b10) begin
            e_adr = 32'h0000_0020;
            e_dat = 32'h1234_5678;
            e_we  = 1'b0;
            e_sel = 4'h3;
        end
        checkField(tag, "grant",   32'(grant),   32'(v.e_grant));
        checkField(tag, "s_cyc",   32'(s_cyc),   32'(v.e_scyc));
        checkField(tag, "s_stb",   32'(s_stb),   32'(v.e_sstb));
        checkField(tag, "m_ack",   32'(m_ack),   32'(v.e_mack));
        checkField(tag, "m_err",   32'(m_err),   32'(v.e_merr));
        checkField(tag, "s_adr",   s_adr,        e_adr);
        checkField(tag, "s_dat_w", s_dat_w,      e_dat);
        checkField(tag, "s_we",    32'(s_we),    32'(e_we));
        checkField(tag, "s_sel",   32'(s_sel),   32'(e_sel));
        checkField(tag, "m_dat_r", m_dat_r,      exp_dat_r);
    endtask

    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        #3;
        checkOutput(v, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nv          = 0;
        exp_dat_r   = '0;
        reset_n     = 1'b0;
        m_cyc       = '0;
        m_stb       = '0;
        s_ack       = 1'b0;
        s_dat_r     = '0;
        m_we        = 2'b01;
        m_sel       = {4'h3, 4'hF};
        m_adr       = {32'h0000_0020, 32'h0000_0010};
        m_dat_w     = {32'h1234_5678, 32'hDEAD_BEEF};

        // single master: grant a cycle late, ack on the second slave cycle
        addVec(mk(1, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00));
        addVec(mk(1, 2'b01, 2'b01, 1, 2'b01, 1, 1, 2'b01, 2'b00));
        addVec(mk(1, 2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        // contention from reset, dead cycle between owners, third request back to 0
        addVec(mk(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 1, 2'b01, 1, 1, 2'b01, 2'b00));
        addVec(mk(1, 2'b10, 2'b10, 0, 2'b01, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b10, 2'b10, 1, 2'b10, 1, 1, 2'b10, 2'b00));
        addVec(mk(1, 2'b01, 2'b01, 0, 2'b10, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00));
        // master 1 holds the bus over three beats while master 0 waits
        addVec(mk(1, 2'b10, 2'b10, 0, 2'b01, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 2'b00));
        addVec(mk(1, 2'b11, 2'b01, 0, 2'b10, 1, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 2'b00));
        addVec(mk(1, 2'b01, 2'b01, 0, 2'b10, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b01, 2'b01, 1, 2'b01, 1, 1, 2'b01, 2'b00));
        addVec(mk(1, 2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00));
        // watchdog abort on the fourth unacked cycle, then ABORT, then re-arbitration
        addVec(mk(1, 2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b10, 2'b10, 0, 2'b10, 1, 1, 2'b00, 2'b00));
        addVec(mk(1, 2'b10, 2'b10, 0, 2'b10, 1, 1, 2'b00, 2'b00));
        addVec(mk(1, 2'b10, 2'b10, 0, 2'b10, 1, 1, 2'b00, 2'b00));
        addVec(mk(1, 2'b10, 2'b10, 0, 2'b10, 0, 0, 2'b00, 2'b10));
        addVec(mk(1, 2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        // ack coinciding with terminal count keeps the cycle alive
        addVec(mk(1, 2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 1, 2'b01, 1, 1, 2'b01, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00));
        // reset mid-transfer restores master 0 priority
        addVec(mk(0, 2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b11, 2'b11, 1, 2'b01, 1, 1, 2'b01, 2'b00));
        addVec(mk(1, 2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        // strobe without cycle is not a request
        addVec(mk(1, 2'b00, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        addVec(mk(1, 2'b00, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00));

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < nv; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // A stb-low gap restarts the stall count: no err until four fresh stalls.
        runVector(mk(1, 2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b00), "wdgap_req");
        for (int i = 0; i < 3; i++) begin
            runVector(mk(1, 2'b10, 2'b10, 0, 2'b10, 1, 1, 2'b00, 2'b00), $sformatf("wdgap_a%0d", i));
        end
        runVector(mk(1, 2'b10, 2'b00, 0, 2'b10, 1, 0, 2'b00, 2'b00), "wdgap_lo");
        for (int i = 0; i < 3; i++) begin
            runVector(mk(1, 2'b10, 2'b10, 0, 2'b10, 1, 1, 2'b00, 2'b00), $sformatf("wdgap_b%0d", i));
        end
        runVector(mk(1, 2'b10, 2'b10, 0, 2'b10, 0, 0, 2'b00, 2'b10), "wdgap_err");
        runVector(mk(1, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00), "wdgap_abort");
        runVector(mk(1, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00), "wdgap_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Round-robin Wishbone arbiter that shares one Wishbone slave port between up to four masters, for example the potato core and the pci_mini bridge contending for the pwm register slave. A grant is held for a whole bus cycle (m_cyc high). A watchdog terminates any cycle whose slave never acks, returning err to the master. The arbiter adds one cycle of grant latency; after grant, the path is combinational master→slave and slave→master.

Parameters:
NUM_MASTERS, 2, number of requesting masters (legal 2..4)
ADR_W, 32, address width
DAT_W, 32, data width (sel width = DAT_W/8)
TIMEOUT, 255, cycles of stb without ack before abort; 0 disables the watchdog

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
m_cyc  in  NUM_MASTERS  per-master cycle request
m_stb  in  NUM_MASTERS  per-master strobe
m_we  in  NUM_MASTERS  per-master write enable
m_sel  in  NUM_MASTERS*DAT_W/8  byte selects, master i at [i*4+:4]
m_adr  in  NUM_MASTERS*ADR_W  addresses, master i at [i*ADR_W+:ADR_W]
m_dat_w  in  NUM_MASTERS*DAT_W  write data, flattened the same way
m_dat_r  out  DAT_W  read data, broadcast to all masters
m_ack  out  NUM_MASTERS  ack, routed to the granted master only
m_err  out  NUM_MASTERS  watchdog abort, one-cycle pulse
s_cyc, s_stb, s_we  out  1  slave-side controls
s_sel  out  DAT_W/8  slave byte selects
s_adr  out  ADR_W  slave address
s_dat_w  out  DAT_W  slave write data
s_dat_r  in  DAT_W  slave read data
s_ack  in  1  slave acknowledge
grant  out  NUM_MASTERS  one-hot current owner (all zero when idle)

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE; grant=0; last-owner pointer=NUM_MASTERS-1, so master 0 has first priority; watchdog=0. s_cyc, s_stb, m_ack and m_err are 0. s_* data/address outputs are 0 while no master is granted.
- FSM states: IDLE, BUSY, ABORT.
- IDLE:
  - If any m_cyc bit is set, search starts at (last+1) mod NUM_MASTERS, ascending and wrapping.
  - The first requester found is registered into grant, last is updated, and the FSM moves to BUSY.
  - The grant is visible on the cycle after the request.
- BUSY:
  - s_cyc = m_cyc[g], s_stb = m_stb[g]; we, sel, adr and dat_w are muxed from master g.
  - m_ack[g] = s_ack & m_stb[g]; other m_ack bits are 0.
  - m_dat_r = s_dat_r at all times.
- Release: when m_cyc[g] is 0 at a clk edge, grant clears and the FSM returns to IDLE. There is one dead cycle before the next grant, even with other masters waiting. A master that keeps cyc high holds the bus (burst/lock semantics).
- Watchdog:
  - Increments each BUSY cycle with s_stb=1 and s_ack=0.
  - Clears on s_ack, on stb low, and on leaving BUSY.
  - When it reaches TIMEOUT (TIMEOUT≠0), m_err[g] pulses high for 1 cycle, s_cyc/s_stb are forced 0, and the FSM enters ABORT.
- ABORT: grant is cleared and the FSM goes to IDLE next cycle. The aborted master is expected to drop cyc; if it keeps cyc high it is re-arbitrated normally, after the other requesters in round-robin order.
- Simultaneous s_ack and watchdog terminal count: ack wins, and no err is raised.
- Request edge cases:
  - Requests that arrive while another master is in BUSY wait.
  - m_stb without m_cyc is ignored.
- Reset mid-cycle: everything returns to reset values on that edge. s_cyc drops immediately, with no ack or err delivered.
- The watchdog counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.

Decomposition:
- Package wb_arb_pkg holds:
  - the state enum (IDLE/BUSY/ABORT);
  - a function rr_pick(req, last) returning a one-hot vector;
  - the constant SEL_W = DAT_W/8.
- Sub-module wb_arb_watchdog holds the counter, the clear logic and the terminal-count pulse, and is instantiated once. The mux and the FSM stay in the top.

Test Plan:
- Single master (NUM_MASTERS=2): m_cyc[0]=m_stb[0]=1, adr=0x10, we=1, dat=0xDEADBEEF, slave acks on its 2nd cycle → grant=01 one cycle after request; s_adr=0x10, s_dat_w=0xDEADBEEF; m_ack[0] pulses once; m_ack[1]=0.
- Contention: m_cyc=11 asserted together from reset → master 0 granted first. After it drops cyc, there is one idle cycle, then grant=10. A third simultaneous request is granted back to master 0.
- Hold: master 1 keeps cyc high over 3 acked stb beats while master 0 requests → master 0 stays ungranted until master 1 drops cyc.
- Timeout (TIMEOUT=4): granted master's stb stays high and the slave never acks → m_err pulses on the 4th non-acked cycle; s_cyc=0 the same cycle; ABORT; grant=0 the next cycle.
- Ack at terminal count (TIMEOUT=4): s_ack arrives in the 4th cycle → m_ack is asserted, m_err stays 0, and the FSM remains BUSY.
- Reset mid-BUSY: reset_n=0 for one edge during a transfer → grant=0, s_cyc=0, and master 0 has priority on the next request.
